// File: rtl/snake_pkg.sv
// Shared types and constants for the snake LED stepper.
package snake_pkg;

  localparam int SPEED_W = 2;
  localparam logic [SPEED_W-1:0] SPD_SHIFT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

endpackage

// File: rtl/snake_step_ctrl_if.sv
// Control/status bundle between the snake stepper and its user.
interface snake_step_ctrl_if #(
  parameter int CNT_MAX = 8
);
  import snake_pkg::*;

  logic               run;
  logic               step_req;
  logic [SPEED_W-1:0] speed;
  logic               dir;
  logic [3:0]         head;
  logic [CNT_MAX-1:0] led;
  logic               step;
  logic               wrap;
  logic               busy;

  modport master (
    output run, step_req, speed, dir,
    input  head, led, step, wrap, busy
  );

  modport slave (
    input  run, step_req, speed, dir,
    output head, led, step, wrap, busy
  );

endinterface

// File: rtl/step_prescaler.sv
// Loadable down-counter that parks at zero and flags it.
module step_prescaler #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic         i_clr,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_val;
    else if (i_dec && r_cnt != '0)
      r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake LED stepper: IDLE/RUN/STEP sequencer, head position and body mask.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int CNT_MAX  = 8,
  parameter int LEN      = 3,
  parameter int BASE_DIV = 2500000,
  parameter int PRESC_W  = 26
) (
  input logic              clk,
  input logic              rst,
  snake_step_ctrl_if.slave bus
);

  state_t r_state, w_nxt;
  logic w_load, w_dec, w_clr, w_adv, w_zero;
  logic [PRESC_W-1:0] w_p, w_load_val;
  logic [3:0] r_head, w_head_nxt;
  logic [CNT_MAX-1:0] r_led, w_led_nxt;
  logic r_step, r_wrap, r_busy;
  logic w_wrap_nxt, w_hi, w_lo;

  // Period P; the counter runs P-2..0 so STEP+RUN spans exactly P cycles.
  assign w_p        = PRESC_W'(BASE_DIV) << (SPD_SHIFT - bus.speed);
  assign w_load_val = w_p - PRESC_W'(2);

  step_prescaler #(.W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_dec (w_dec),
    .i_clr (w_clr),
    .i_val (w_load_val),
    .o_zero(w_zero)
  );

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_clr  = 1'b0;
    w_adv  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.run) begin
          w_nxt  = RUN;
          w_load = 1'b1;
        end else if (bus.step_req) begin
          w_nxt = STEP;
          w_adv = 1'b1;
        end
      end
      RUN: begin
        if (!bus.run) begin
          w_nxt = IDLE;
          w_clr = 1'b1;
        end else if (w_zero) begin
          w_nxt = STEP;
          w_adv = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      STEP: begin
        if (bus.run) begin
          w_nxt  = RUN;
          w_load = 1'b1;
        end else begin
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  assign w_hi = (r_head == 4'(CNT_MAX - 1));
  assign w_lo = (r_head == 4'd0);

  always_comb begin
    if (!bus.dir) begin
      w_wrap_nxt = w_hi;
      w_head_nxt = w_hi ? 4'd0 : r_head + 4'd1;
    end else begin
      w_wrap_nxt = w_lo;
      w_head_nxt = w_lo ? 4'(CNT_MAX - 1) : r_head - 4'd1;
    end
  end

  // Body trails below the new head regardless of travel direction.
  always_comb begin
    w_led_nxt = '0;
    for (int k = 0; k < LEN; k++) begin
      int idx;
      idx = (int'(w_head_nxt) + CNT_MAX - k) % CNT_MAX;
      w_led_nxt = w_led_nxt | (CNT_MAX'(1) << idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_led   <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_step  <= w_adv;
      r_wrap  <= w_adv & w_wrap_nxt;
      r_busy  <= (w_nxt != IDLE);
      if (w_adv) begin
        r_head <= w_head_nxt;
        r_led  <= w_led_nxt;
      end
    end
  end

  assign bus.head = r_head;
  assign bus.led  = r_led;
  assign bus.step = r_step;
  assign bus.wrap = r_wrap;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with a 4-clock base period.
module tb_snake_step_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  snake_step_ctrl_if #(.CNT_MAX(8)) bus ();

  snake_step_ctrl #(
    .CNT_MAX (8),
    .LEN     (3),
    .BASE_DIV(4),
    .PRESC_W (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.step && n < lim);
    if (!bus.step) check("step_timeout", 0, 1);
  endtask

  int n;
  int n2;
  logic saw;

  initial begin
    bus.run      = 1'b0;
    bus.step_req = 1'b0;
    bus.speed    = 2'd3;
    bus.dir      = 1'b0;
    tick();
    tick();
    check("rst_head", bus.head, 0);
    check("rst_led", bus.led, 0);
    check("rst_step", bus.step, 0);
    check("rst_wrap", bus.wrap, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    tick();

    // manual step backwards from head 0
    bus.dir      = 1'b1;
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    check("man_step", bus.step, 1);
    check("man_head", bus.head, 7);
    check("man_wrap", bus.wrap, 1);
    check("man_led", bus.led, 32'hE0);
    check("man_busy", bus.busy, 1);
    tick();
    check("man_step_off", bus.step, 0);
    check("man_busy_off", bus.busy, 0);
    check("man_head_hold", bus.head, 7);

    #2 rst = 1'b1;
    #1;
    check("arst_head", bus.head, 0);
    rst = 1'b0;
    tick();

    // free run forward at speed 3
    bus.dir = 1'b0;
    bus.run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_step(100, n);
      check("run_per", n, 4);
      check("run_head", bus.head, (k + 1) % 8);
      check("run_wrap", bus.wrap, (k == 7) ? 1 : 0);
      if (k == 1) check("run_led2", bus.led, 32'h07);
      if (k == 0) begin
        tick();
        check("run_pulse_w", bus.step, 0);
        check("run_busy", bus.busy, 1);
        wait_step(100, n);
        check("run_per_b", n + 1, 4);
        check("run_head_b", bus.head, 2);
        k++;
        check("run_led2", bus.led, 32'h07);
      end
    end

    // step_req held across STEP and RUN adds nothing
    bus.step_req = 1'b1;
    tick();
    tick();
    bus.step_req = 1'b0;
    wait_step(100, n);
    check("req_ign_per", n, 2);
    check("req_ign_head", bus.head, 1);

    // slow speed, then mid-period change
    bus.speed = 2'd0;
    wait_step(100, n);
    check("slow_per", n, 32);
    check("slow_head", bus.head, 2);
    repeat (6) tick();
    bus.speed = 2'd3;
    wait_step(100, n);
    check("spd_mid_per", n + 6, 32);
    check("spd_mid_head", bus.head, 3);
    wait_step(100, n);
    check("spd_new_per", n, 4);
    check("spd_new_head", bus.head, 4);

    // drop run two cycles before the step is due
    tick();
    tick();
    bus.run = 1'b0;
    tick();
    check("drop_busy", bus.busy, 0);
    saw = bus.step;
    for (int k = 0; k < 10; k++) begin
      tick();
      saw = saw | bus.step;
    end
    check("drop_nostep", saw, 0);
    check("drop_head", bus.head, 4);

    // reset mid-period
    bus.run = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_head", bus.head, 0);
    check("mid_rst_led", bus.led, 0);
    check("mid_rst_busy", bus.busy, 0);
    #1 rst = 1'b0;
    wait_step(100, n2);
    check("post_rst_per", n2, 4);
    check("post_rst_head", bus.head, 1);
    check("post_rst_led", bus.led, 32'h83);
    check("post_rst_wrap", bus.wrap, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/snake_step_ctrl.md
SNAKE_STEP_CTRL -- requirements
Module: snake_step_ctrl

Interface
REQ-001 SHALL have parameter CNT_MAX, default 8: number of LED positions, range 2..16.
REQ-002 SHALL have parameter LEN, default 3: snake body length, range 1..CNT_MAX.
REQ-003 SHALL have parameter BASE_DIV, default 2500000: fastest step period in clocks, minimum 2.
REQ-004 SHALL have parameter PRESC_W, default 26: prescaler width, at least clog2(BASE_DIV*8).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port run, input, 1: level; 1 = free-running stepping.
REQ-008 SHALL have port step_req, input, 1: one-cycle manual step request, honoured only in IDLE.
REQ-009 SHALL have port speed, input, 2: speed level; 3 = fastest.
REQ-010 SHALL have port dir, input, 1: 0 = head increments, 1 = head decrements.
REQ-011 SHALL have port head, output, 4: current head position, registered.
REQ-012 SHALL have port led, output, CNT_MAX: body mask, registered.
REQ-013 SHALL have port step, output, 1: one-cycle pulse, high in the cycle the new head/led first appear.
REQ-014 SHALL have port wrap, output, 1: one-cycle pulse coincident with step when head wraps.
REQ-015 SHALL have port busy, output, 1: high in RUN and STEP.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and STEP.
REQ-017 IDLE SHALL go to RUN if run=1, else to STEP if step_req=1, else stay in IDLE; run SHALL win when both are high, and step_req SHALL then be dropped.
REQ-018 On entering RUN or re-entering RUN from STEP, the block SHALL load presc with P-2, where P = BASE_DIV << (3-speed) and speed is sampled at that load only.
REQ-019 RUN SHALL decrement presc each cycle and go to STEP at the edge where presc==0 and run=1.
REQ-020 RUN with run=0 SHALL go to IDLE next edge, clear presc and leave head/led unchanged.
REQ-021 STEP SHALL last exactly one cycle, then go to RUN if run=1, else to IDLE.
REQ-022 In RUN, consecutive step pulses SHALL be exactly P cycles apart.
REQ-023 At the edge entering STEP, head SHALL advance by ±1 per dir sampled at that edge, modulo CNT_MAX.
REQ-024 wrap SHALL be high when head goes CNT_MAX-1→0 (dir=0) or 0→CNT_MAX-1 (dir=1).
REQ-025 At that same edge, led SHALL be set to bits head_new, head_new-1, ..., head_new-(LEN-1) mod CNT_MAX (trailing from the new head, independent of dir), all other bits 0.
REQ-026 step_req in RUN or STEP SHALL be ignored; no queuing.
REQ-027 A dir change mid-period SHALL take effect only at the next step.
REQ-028 A speed change mid-period SHALL take effect only at the next reload.
REQ-029 All arithmetic SHALL be unsigned; head SHALL never leave 0..CNT_MAX-1.

Reset
REQ-030 rst=1 SHALL force, asynchronously, state=IDLE, presc=0, head=0, led=0, step=0, wrap=0 and busy=0.
REQ-031 Reset asserted mid-period SHALL discard the partial count; the first step after release SHALL produce head=1 (dir=0).

Structure
REQ-032 Package snake_pkg SHALL hold the state enum, SPEED_W=2 and the speed-shift constant 3.
REQ-033 The prescaler SHALL be a sub-module step_prescaler (load, decrement, zero flag); the FSM, head and mask logic SHALL stay in snake_step_ctrl.

Verification
REQ-034 Use BASE_DIV=4, CNT_MAX=8, LEN=3; with run=1, speed=3, dir=0: step every 4 cycles; head 1,2,...,7,0; wrap only with head=0; led=8'h07 at head=2.
REQ-035 With speed=0: step period 32 cycles; a switch to speed=3 mid-period leaves the current period at 32 and makes the next 4.
REQ-036 From reset, with head=0 and dir=1 on the first step: head=7, wrap=1, led=8'hE0.
REQ-037 In IDLE, a step_req pulse gives step exactly one cycle later and busy=1 for one cycle; step_req pulses during RUN give no extra step.
REQ-038 Drop run 2 cycles before the step is due: no step occurs, head is unchanged, busy=0 on the next cycle.
REQ-039 Assert rst mid-period: outputs clear immediately with no clock; after release, the next step gives head=1, led=8'h83.
